// File: rtl/dbus_responder.sv
// Single-outstanding data-bus responder backed by a 64-bit word memory.
// A request is accepted in IDLE. Its address, strobe and data are captured.
// After LATENCY cycles the memory access completes. A read returns the word.
// A write updates the strobed byte lanes and returns the pre-write word.
module dbus_responder #(
    parameter int          LATENCY    = 2,
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        busy
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0]   idx_reg;
    logic [7:0]              strobe_reg;
    logic [63:0]             data_reg;
    logic [63:0]             rd_data_reg;
    logic [63:0]             mem [WORDS];

    logic [63:0]             offset;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    accept;
    logic                    complete;

    // Word index relative to the window base; the high bits wrap and the byte offset is dropped.
    assign offset  = req_addr - BASE_ADDR;
    assign req_idx = offset[DEPTH_LOG2+2:3];

    // req_size is carried on the bus but does not influence behaviour.
    logic unused_bits;
    assign unused_bits = ^{req_size, offset[63:DEPTH_LOG2+3], offset[2:0]};

    // Next-state logic: accept in IDLE, count down in WAIT, complete when the count hits zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && !reset) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    cnt_next   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    // A reset in the final cycle abandons the transaction with no response or write.
                    complete   = !reset;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and countdown registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request at acceptance; later changes on req_* are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_reg    <= req_idx;
            strobe_reg <= req_strobe;
            data_reg   <= req_data;
        end
    end

    // In IDLE, read the incoming index so the word is available one cycle after acceptance.
    // This covers LATENCY = 1. Only this block writes the memory.
    // At most one transaction is outstanding.
    // The word therefore cannot change between acceptance and completion.
    assign rd_idx = (state_reg == IDLE) ? req_idx : idx_reg;

    // Memory with registered read and byte-lane writes at the completion edge. It is never cleared.
    always_ff @(posedge clk) begin
        rd_data_reg <= mem[rd_idx];
        if (complete) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_reg[i]) begin
                    mem[idx_reg][8*i +: 8] <= data_reg[8*i +: 8];
                end
            end
        end
    end

    assign resp_addr_ok = accept;
    assign resp_data_ok = complete;
    assign resp_data    = complete ? rd_data_reg : 64'd0;
    assign busy         = (state_reg == WAIT);

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder with LATENCY = 2 and DEPTH_LOG2 = 10.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, well before the rising edge.
module tb_dbus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [63:0] resp_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    dbus_responder #(
        .LATENCY   (2),
        .DEPTH_LOG2(10),
        .BASE_ADDR (64'h8000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_strobe  (req_strobe),
        .req_data    (req_data),
        .resp_addr_ok(resp_addr_ok),
        .resp_data_ok(resp_data_ok),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // The caller is positioned just after a falling edge.
    // The request is presented this cycle (t). Completion is expected at t+2.
    // With keep = 1, req_valid stays high after return for a back-to-back request.
    task automatic txn(input string name, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, input bit chk_rd, input logic [63:0] expv,
                       input bit scramble, input bit keep);
        req_valid  = 1'b1;
        req_addr   = a;
        req_strobe = s;
        req_data   = d;
        req_size   = 3'd3;
        #1;
        chk({name, " addr_ok@t"}, 64'(resp_addr_ok), 64'd1);
        chk({name, " busy@t"}, 64'(busy), 64'd0);
        @(negedge clk);
        if (scramble) begin
            req_addr   = 64'h8000_0010;
            req_strobe = 8'hFF;
            req_data   = 64'h0BAD_0BAD_0BAD_0BAD;
            req_size   = 3'd0;
        end
        #1;
        chk({name, " busy@t+1"}, 64'(busy), 64'd1);
        chk({name, " addr_ok@t+1"}, 64'(resp_addr_ok), 64'd0);
        chk({name, " data_ok@t+1"}, 64'(resp_data_ok), 64'd0);
        @(negedge clk);
        #1;
        chk({name, " data_ok@t+2"}, 64'(resp_data_ok), 64'd1);
        chk({name, " busy@t+2"}, 64'(busy), 64'd1);
        chk({name, " addr_ok@t+2"}, 64'(resp_addr_ok), 64'd0);
        if (chk_rd) chk({name, " resp_data"}, resp_data, expv);
        $display("txn %s addr=%h strobe=%h data=%h resp_data=%h", name, a, s, d, resp_data);
        if (!keep) req_valid = 1'b0;
    endtask

    // One cycle later with no request pending: the responder must be idle with quiet outputs.
    task automatic idle_chk(input string name);
        @(negedge clk);
        #1;
        chk({name, " idle busy"}, 64'(busy), 64'd0);
        chk({name, " idle data_ok"}, 64'(resp_data_ok), 64'd0);
        chk({name, " idle resp_data"}, resp_data, 64'd0);
        chk({name, " idle addr_ok"}, 64'(resp_addr_ok), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 64'h8000_0008;
        req_size   = 3'd3;
        req_strobe = 8'hFF;
        req_data   = 64'h0;

        // A request is present during reset and must not be accepted.
        @(negedge clk);
        #1;
        chk("reset addr_ok", 64'(resp_addr_ok), 64'd0);
        @(negedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset data_ok", 64'(resp_data_ok), 64'd0);
        chk("reset resp_data", resp_data, 64'd0);
        $display("txn reset with req_valid high");
        req_valid = 1'b0;
        reset     = 1'b0;
        idle_chk("post-reset");

        // Full write, then read back.
        @(negedge clk);
        txn("wr full", 64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 1'b0, 1'b0);
        idle_chk("wr full");
        @(negedge clk);
        txn("rd full", 64'h8000_0008, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b0);
        idle_chk("rd full");

        // Partial write at an unaligned address. The response returns the pre-write word.
        @(negedge clk);
        txn("wr lanes0-3", 64'h8000_000C, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b1,
            64'h1122_3344_5566_7788, 1'b0, 1'b0);
        idle_chk("wr lanes0-3");

        // Back-to-back requests. The first is a read whose inputs are scrambled mid-wait.
        // The second is a write through the wrapped address window.
        @(negedge clk);
        txn("rd merged", 64'h8000_0008, 8'h00, 64'h0, 1'b1, 64'h1122_3344_BBBB_BBBB, 1'b1, 1'b1);
        req_addr   = 64'h8000_2000;
        req_strobe = 8'hFF;
        req_data   = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        txn("wr wrap b2b", 64'h8000_2000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h0, 1'b0, 1'b0);
        idle_chk("wr wrap b2b");
        @(negedge clk);
        txn("rd wrap", 64'h8000_0000, 8'h00, 64'h0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
        idle_chk("rd wrap");

        // Scrambled strobe and data must not have overwritten word 1.
        @(negedge clk);
        txn("rd after scramble", 64'h8000_0008, 8'h00, 64'h0, 1'b1, 64'h1122_3344_BBBB_BBBB,
            1'b0, 1'b0);
        idle_chk("rd after scramble");

        // Reset during the wait abandons a pending write.
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 64'h8000_0008;
        req_strobe = 8'hFF;
        req_data   = 64'h0;
        #1;
        chk("abort addr_ok@t", 64'(resp_addr_ok), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("abort data_ok@t+1", 64'(resp_data_ok), 64'd0);
        @(negedge clk);
        #1;
        chk("abort busy@t+2", 64'(busy), 64'd0);
        chk("abort data_ok@t+2", 64'(resp_data_ok), 64'd0);
        chk("abort resp_data@t+2", resp_data, 64'd0);
        $display("txn reset during wait on write addr=8000_0008");
        reset = 1'b0;
        @(negedge clk);
        txn("rd after abort", 64'h8000_0008, 8'h00, 64'h0, 1'b1, 64'h1122_3344_BBBB_BBBB,
            1'b0, 1'b0);
        idle_chk("rd after abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
